// File: rtl/stage_ex_pipe.sv
// stage_ex_pipe -- execute stage of the 5-stage RV core.
//
// Purpose:
//   Sits between ID and MEM. Single-cycle ALU/branch path plus an iterative
//   M-extension multiply/divide unit (one bit per cycle, fixed latency).
//   Every EX->MEM output is registered and qualified by out_valid.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush_in         kills the in-flight mul/div op and the output register
//   in_valid/ready   ID -> EX handshake
//   memOp_in, wdOp_in, exOp_in, mdOp_in   op controls
//   rs1Data_in, rs2Data_in, imm_in, pc_in operands
//   out_valid/ready  EX -> MEM handshake
//   memOp_out, wdOp_out, rs2Data_out, exResult_out, jumpEn_out, jumpAddr_out
//   busy_out         mul/div FSM not idle
//
// exOp_in: [0] workEn, [1] cptSelect, [2] srcA=pc, [3] srcB=imm, [7:4] cptOp
//   cptSelect=0: ALU, cptOp = {funct7[5], funct3} (sub / sra on bit 3)
//   cptSelect=1: cptOp[3]=1 unconditional jump (rs1+imm), else branch funct3
module stage_ex_pipe #(
    parameter int BUS_W    = 32,
    parameter int MEM_OP_W = 5,
    parameter int WD_OP_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MEM_OP_W-1:0] memOp_in,
    input  logic [WD_OP_W-1:0]  wdOp_in,
    input  logic [7:0]          exOp_in,
    input  logic [3:0]          mdOp_in,
    input  logic [BUS_W-1:0]    rs1Data_in,
    input  logic [BUS_W-1:0]    rs2Data_in,
    input  logic [BUS_W-1:0]    imm_in,
    input  logic [BUS_W-1:0]    pc_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MEM_OP_W-1:0] memOp_out,
    output logic [WD_OP_W-1:0]  wdOp_out,
    output logic [BUS_W-1:0]    rs2Data_out,
    output logic [BUS_W-1:0]    exResult_out,
    output logic                jumpEn_out,
    output logic [BUS_W-1:0]    jumpAddr_out,
    output logic                busy_out
);

    localparam int CNT_W = $clog2(BUS_W);
    localparam int SHW   = $clog2(BUS_W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} md_state_t;

    md_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        md_f3;
    logic              neg_a, neg_b, div_zero;
    logic [BUS_W-1:0]  acc_hi, acc_lo, opnd_b;
    logic [MEM_OP_W-1:0] md_mem;
    logic [WD_OP_W-1:0]  md_wd;
    logic [BUS_W-1:0]    md_rs2;

    logic jump_q;

    // ---------------- handshake ----------------
    logic busy, out_free, accept, accept_alu, accept_md, load_md;

    assign busy       = (state != S_IDLE);
    assign busy_out   = busy;
    assign out_free   = !out_valid || out_ready;
    assign in_ready   = !rst && !busy && out_free && !flush_in;
    assign accept     = in_valid && in_ready;
    assign accept_alu = accept && !mdOp_in[3];
    assign accept_md  = accept && mdOp_in[3];
    assign load_md    = (state == S_FIN) && out_free;

    // ---------------- ALU / branch ----------------
    logic             work_en, cpt_sel;
    logic [3:0]       cpt_op;
    logic [BUS_W-1:0] src_a, src_b, alu_res;
    logic [SHW-1:0]   shamt;
    logic             br_taken;

    assign work_en = exOp_in[0];
    assign cpt_sel = exOp_in[1];
    assign cpt_op  = exOp_in[7:4];
    assign src_a   = exOp_in[2] ? pc_in  : rs1Data_in;
    assign src_b   = exOp_in[3] ? imm_in : rs2Data_in;
    assign shamt   = src_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (cpt_op[2:0])
            3'b000: alu_res = cpt_op[3] ? src_a - src_b : src_a + src_b;
            3'b001: alu_res = src_a << shamt;
            3'b010: alu_res = {{(BUS_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            3'b011: alu_res = {{(BUS_W-1){1'b0}}, src_a < src_b};
            3'b100: alu_res = src_a ^ src_b;
            3'b101: alu_res = cpt_op[3] ? BUS_W'($signed(src_a) >>> shamt) : src_a >> shamt;
            3'b110: alu_res = src_a | src_b;
            default: alu_res = src_a & src_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (cpt_op[2:0])
            3'b000: br_taken = (rs1Data_in == rs2Data_in);
            3'b001: br_taken = (rs1Data_in != rs2Data_in);
            3'b100: br_taken = $signed(rs1Data_in) <  $signed(rs2Data_in);
            3'b101: br_taken = $signed(rs1Data_in) >= $signed(rs2Data_in);
            3'b110: br_taken = rs1Data_in <  rs2Data_in;
            3'b111: br_taken = rs1Data_in >= rs2Data_in;
            default: br_taken = 1'b0;
        endcase
    end

    logic [BUS_W-1:0] alu_out, jmp_tgt;
    logic             jmp_en;

    assign alu_out = work_en ? (cpt_sel ? pc_in + BUS_W'(4) : alu_res) : imm_in;
    assign jmp_en  = work_en && cpt_sel && (br_taken || cpt_op[3]);
    assign jmp_tgt = cpt_op[3] ? rs1Data_in + imm_in : pc_in + imm_in;

    // ---------------- mul/div operand prep ----------------
    logic             in_sa, in_sb, in_na, in_nb;
    logic [BUS_W-1:0] in_mag_a, in_mag_b;

    // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
    // MUL is run unsigned; the low half of the product does not depend on sign.
    assign in_sa    = (mdOp_in[2:0] == 3'b001) || (mdOp_in[2:0] == 3'b010) ||
                      (mdOp_in[2:0] == 3'b100) || (mdOp_in[2:0] == 3'b110);
    assign in_sb    = (mdOp_in[2:0] == 3'b001) || (mdOp_in[2:0] == 3'b100) ||
                      (mdOp_in[2:0] == 3'b110);
    assign in_na    = in_sa && rs1Data_in[BUS_W-1];
    assign in_nb    = in_sb && rs2Data_in[BUS_W-1];
    assign in_mag_a = in_na ? -rs1Data_in : rs1Data_in;
    assign in_mag_b = in_nb ? -rs2Data_in : rs2Data_in;

    // ---------------- iteration step ----------------
    // mul: {acc_hi, acc_lo} shifts right, acc_lo starts as the multiplier.
    // div: {acc_hi, acc_lo} shifts left, acc_hi is the partial remainder and
    //      quotient bits enter at acc_lo[0].
    logic [BUS_W:0]   mul_sum, div_t;
    logic [BUS_W+1:0] div_diff;
    logic             div_borrow;

    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    assign div_t      = {acc_hi, acc_lo[BUS_W-1]};
    assign div_diff   = {1'b0, div_t} - {2'b00, opnd_b};
    assign div_borrow = div_diff[BUS_W+1];

    // ---------------- sign fix ----------------
    logic [2*BUS_W-1:0] prod, prod_s;
    logic [BUS_W-1:0]   quo_s, rem_s, md_res;

    assign prod   = {acc_hi, acc_lo};
    assign prod_s = (neg_a ^ neg_b) ? -prod : prod;
    // Divide-by-zero already yields all-ones quotient and the dividend
    // magnitude as remainder; only the quotient negation has to be blocked.
    // min / -1 needs nothing: the magnitude quotient is min and negating it
    // leaves it unchanged.
    assign quo_s  = ((neg_a ^ neg_b) && !div_zero) ? -acc_lo : acc_lo;
    assign rem_s  = neg_a ? -acc_hi : acc_hi;

    always_comb begin
        md_res = '0;
        case (md_f3)
            3'b000:         md_res = prod_s[BUS_W-1:0];
            3'b001, 3'b010,
            3'b011:         md_res = prod_s[2*BUS_W-1:BUS_W];
            3'b100, 3'b101: md_res = quo_s;
            default:        md_res = rem_s;
        endcase
    end

    // ---------------- mul/div FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            md_f3    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_b   <= '0;
            md_mem   <= '0;
            md_wd    <= '0;
            md_rs2   <= '0;
        end else if (flush_in) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_md) begin
                        md_f3    <= mdOp_in[2:0];
                        neg_a    <= in_na;
                        neg_b    <= in_nb;
                        div_zero <= (rs2Data_in == '0);
                        acc_hi   <= '0;
                        acc_lo   <= in_mag_a;
                        opnd_b   <= in_mag_b;
                        md_mem   <= memOp_in;
                        md_wd    <= wdOp_in;
                        md_rs2   <= rs2Data_in;
                        cnt      <= CNT_W'(BUS_W-1);
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (md_f3[2]) begin
                        acc_hi <= div_borrow ? div_t[BUS_W-1:0] : div_diff[BUS_W-1:0];
                        acc_lo <= {acc_lo[BUS_W-2:0], ~div_borrow};
                    end else begin
                        acc_hi <= mul_sum[BUS_W:1];
                        acc_lo <= {mul_sum[0], acc_lo[BUS_W-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= S_FIN;
                end
                S_FIN: begin
                    if (out_free)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            jump_q       <= 1'b0;
            memOp_out    <= '0;
            wdOp_out     <= '0;
            rs2Data_out  <= '0;
            exResult_out <= '0;
            jumpAddr_out <= '0;
        end else if (flush_in) begin
            out_valid <= 1'b0;
            jump_q    <= 1'b0;
        end else if (accept_alu) begin
            out_valid    <= 1'b1;
            jump_q       <= jmp_en;
            memOp_out    <= memOp_in;
            wdOp_out     <= wdOp_in;
            rs2Data_out  <= rs2Data_in;
            exResult_out <= alu_out;
            jumpAddr_out <= jmp_tgt;
        end else if (load_md) begin
            out_valid    <= 1'b1;
            jump_q       <= 1'b0;
            memOp_out    <= md_mem;
            wdOp_out     <= md_wd;
            rs2Data_out  <= md_rs2;
            exResult_out <= md_res;
            jumpAddr_out <= '0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            jump_q    <= 1'b0;
        end
    end

    assign jumpEn_out = jump_q && out_valid;

endmodule
